// File: rtl/step_seq_pkg.sv
// Shared constants for the step-sequencer display: grid geometry and the
// draw arbiter state encoding.
package step_seq_pkg;

   localparam int unsigned GRID_X0    = 214;
   localparam int unsigned GRID_Y0    = 32;
   localparam int unsigned CELL_PITCH = 33;
   localparam int unsigned GRID_N     = 12;

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_IDLE     = 3'd1,
      S_LAUNCH   = 3'd2,
      S_WAIT_HI1 = 3'd3,
      S_WAIT_LO1 = 3'd4,
      S_WAIT_HI2 = 3'd5,
      S_WAIT_LO2 = 3'd6,
      S_ERR      = 3'd7
   } draw_state_t;

endpackage

// File: rtl/grid_to_pixel.sv
// Maps a grid cell index pair to the top-left pixel of that cell.
module grid_to_pixel
   import step_seq_pkg::*;
(
   input  logic [3:0] i_col,
   input  logic [3:0] i_row,
   output logic [9:0] o_x,
   output logic [8:0] o_y
);

   // Indices 0..11 keep both results inside their widths.
   assign o_x = 10'(GRID_X0) + 10'(CELL_PITCH) * 10'(i_col);
   assign o_y = 9'(GRID_Y0) + 9'(CELL_PITCH) * 9'(i_row);

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter between the cursor mover (A) and step editor (B),
// sequencing one two-phase draw operation on vga_display per grant.
module vga_draw_arbiter
   import step_seq_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic       CLOCK_50,
   input  logic       nReset,
   input  logic       reqA,
   input  logic       reqB,
   output logic       ackA,
   output logic       ackB,
   input  logic [3:0] newA_col,
   input  logic [3:0] newA_row,
   input  logic [3:0] oldA_col,
   input  logic [3:0] oldA_row,
   input  logic [3:0] newB_col,
   input  logic [3:0] newB_row,
   input  logic [3:0] oldB_col,
   input  logic [3:0] oldB_row,
   input  logic       stateA,
   input  logic       stateB,
   input  logic       drawing,
   output logic       draw_enable,
   output logic [9:0] X,
   output logic [8:0] Y,
   output logic [9:0] OLD_X,
   output logic [8:0] OLD_Y,
   output logic       state,
   output logic       init_done,
   output logic       busy,
   output logic       err_range,
   output logic       err_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   draw_state_t      r_fsm, w_fsm_next;
   logic             r_init_hi, r_init_done, r_last_b;
   logic [CNT_W-1:0] r_cnt;
   logic [9:0]       r_x, r_old_x;
   logic [8:0]       r_y, r_old_y;
   logic             r_state;

   logic             w_grant_a, w_grant_b, w_latch, w_in_range, w_to_hit;
   logic [3:0]       w_new_col, w_new_row, w_old_col, w_old_row;
   logic [9:0]       w_new_x, w_old_x;
   logic [8:0]       w_new_y, w_old_y;

   // On a tie the requester that was not served last wins.
   assign w_grant_a = reqA && (!reqB || r_last_b);
   assign w_grant_b = reqB && !w_grant_a;

   assign w_new_col = w_grant_a ? newA_col : newB_col;
   assign w_new_row = w_grant_a ? newA_row : newB_row;
   assign w_old_col = w_grant_a ? oldA_col : oldB_col;
   assign w_old_row = w_grant_a ? oldA_row : oldB_row;

   assign w_in_range = (w_new_col < 4'(GRID_N)) && (w_new_row < 4'(GRID_N)) &&
                       (w_old_col < 4'(GRID_N)) && (w_old_row < 4'(GRID_N));

   grid_to_pixel u_new_pix (.i_col(w_new_col), .i_row(w_new_row), .o_x(w_new_x), .o_y(w_new_y));
   grid_to_pixel u_old_pix (.i_col(w_old_col), .i_row(w_old_row), .o_x(w_old_x), .o_y(w_old_y));

   assign w_to_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_latch  = ackA || ackB;

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_fsm_next  = r_fsm;
      ackA        = 1'b0;
      ackB        = 1'b0;
      draw_enable = 1'b0;
      err_range   = 1'b0;
      err_timeout = 1'b0;
      case (r_fsm)
         S_INIT:     if (r_init_hi && !drawing) w_fsm_next = S_IDLE;
         S_IDLE: begin
            if (w_grant_a || w_grant_b) begin
               ackA       = w_grant_a;
               ackB       = w_grant_b;
               w_fsm_next = w_in_range ? S_LAUNCH : S_ERR;
            end
         end
         S_LAUNCH: begin
            draw_enable = 1'b1;
            w_fsm_next  = S_WAIT_HI1;
         end
         S_WAIT_HI1: begin
            if (drawing) w_fsm_next = S_WAIT_LO1;
            else if (w_to_hit) begin
               err_timeout = 1'b1;
               w_fsm_next  = S_IDLE;
            end
         end
         S_WAIT_LO1: if (!drawing) w_fsm_next = S_WAIT_HI2;
         S_WAIT_HI2: begin
            if (drawing) w_fsm_next = S_WAIT_LO2;
            else if (w_to_hit) begin
               err_timeout = 1'b1;
               w_fsm_next  = S_IDLE;
            end
         end
         S_WAIT_LO2: if (!drawing) w_fsm_next = S_IDLE;
         S_ERR: begin
            err_range  = 1'b1;
            w_fsm_next = S_IDLE;
         end
         default:    w_fsm_next = S_INIT;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         r_fsm       <= S_INIT;
         r_init_hi   <= 1'b0;
         r_init_done <= 1'b0;
         r_last_b    <= 1'b1;
         r_cnt       <= '0;
         r_x         <= 10'(GRID_X0);
         r_y         <= 9'(GRID_Y0);
         r_old_x     <= 10'(GRID_X0);
         r_old_y     <= 9'(GRID_Y0);
         r_state     <= 1'b0;
      end else begin
         r_fsm <= w_fsm_next;
         if (r_fsm == S_INIT && drawing) r_init_hi <= 1'b1;
         if (r_fsm == S_INIT && w_fsm_next == S_IDLE) r_init_done <= 1'b1;

         // Counter runs only while waiting for drawing to rise.
         if ((r_fsm == S_WAIT_HI1 || r_fsm == S_WAIT_HI2) && w_fsm_next == r_fsm)
            r_cnt <= r_cnt + CNT_W'(1);
         else
            r_cnt <= '0;

         if (w_latch) begin
            r_last_b <= w_grant_b;
            if (w_in_range) begin
               r_x     <= w_new_x;
               r_y     <= w_new_y;
               r_old_x <= w_old_x;
               r_old_y <= w_old_y;
               r_state <= w_grant_a ? stateA : stateB;
            end
         end
      end
   end

   assign busy      = (r_fsm != S_INIT) && (r_fsm != S_IDLE);
   assign init_done = r_init_done;
   assign X         = r_x;
   assign Y         = r_y;
   assign OLD_X     = r_old_x;
   assign OLD_Y     = r_old_y;
   assign state     = r_state;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: the stimulus thread queues expected
// grants, a negedge monitor pops them on every ack and checks the operation.
module tb_vga_draw_arbiter;

   logic       CLOCK_50 = 1'b0;
   logic       nReset;
   logic       reqA, reqB, ackA, ackB;
   logic [3:0] newA_col, newA_row, oldA_col, oldA_row;
   logic [3:0] newB_col, newB_row, oldB_col, oldB_row;
   logic       stateA, stateB, drawing, draw_enable;
   logic [9:0] X, OLD_X;
   logic [8:0] Y, OLD_Y;
   logic       state, init_done, busy, err_range, err_timeout;

   vga_draw_arbiter #(.TIMEOUT(16)) dut (
      .CLOCK_50(CLOCK_50), .nReset(nReset),
      .reqA(reqA), .reqB(reqB), .ackA(ackA), .ackB(ackB),
      .newA_col(newA_col), .newA_row(newA_row), .oldA_col(oldA_col), .oldA_row(oldA_row),
      .newB_col(newB_col), .newB_row(newB_row), .oldB_col(oldB_col), .oldB_row(oldB_row),
      .stateA(stateA), .stateB(stateB), .drawing(drawing), .draw_enable(draw_enable),
      .X(X), .Y(Y), .OLD_X(OLD_X), .OLD_Y(OLD_Y), .state(state),
      .init_done(init_done), .busy(busy), .err_range(err_range), .err_timeout(err_timeout)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef enum {K_DRAW, K_RANGE, K_TIMEOUT} kind_t;
   typedef struct {
      bit         is_b;
      kind_t      kind;
      logic [9:0] x, ox;
      logic [8:0] y, oy;
      logic       st;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   bit   cur_valid = 0, cur_de = 0, cur_er = 0, cur_et = 0;
   int   n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input bit is_b, input kind_t k, input int x, input int y,
                       input int ox, input int oy, input bit st);
      exp_t e;
      e.is_b = is_b; e.kind = k; e.st = st;
      e.x = 10'(x); e.y = 9'(y); e.ox = 10'(ox); e.oy = 9'(oy);
      sb_q.push_back(e);
   endtask

   // Confirms the operation in flight produced the events its kind requires.
   task automatic close_cur();
      if (cur_valid) begin
         check("op_saw_draw_enable", 32'(cur_de), 32'(cur.kind != K_RANGE));
         check("op_saw_err_range", 32'(cur_er), 32'(cur.kind == K_RANGE));
         check("op_saw_err_timeout", 32'(cur_et), 32'(cur.kind == K_TIMEOUT));
      end
   endtask

   always @(negedge CLOCK_50) begin
      if (ackA || ackB) begin
         close_cur();
         check("queue_nonempty_at_ack", 32'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            cur_valid = 1; cur_de = 0; cur_er = 0; cur_et = 0;
            check("ack_who", {30'd0, ackA, ackB}, cur.is_b ? 32'd1 : 32'd2);
            check("init_done_at_ack", 32'(init_done), 1);
         end
      end
      if (draw_enable) begin
         check("draw_enable_once_for_drawable_op",
               32'(cur_valid && !cur_de && cur.kind != K_RANGE), 1);
         if (cur_valid) begin
            check("X", 32'(X), 32'(cur.x));
            check("Y", 32'(Y), 32'(cur.y));
            check("OLD_X", 32'(OLD_X), 32'(cur.ox));
            check("OLD_Y", 32'(OLD_Y), 32'(cur.oy));
            check("state", 32'(state), 32'(cur.st));
         end
         cur_de = 1;
      end
      if (err_range) begin
         check("err_range_expected", 32'(cur_valid && cur.kind == K_RANGE && !cur_er), 1);
         cur_er = 1;
      end
      if (err_timeout) begin
         check("err_timeout_expected", 32'(cur_valid && cur.kind == K_TIMEOUT && !cur_et), 1);
         cur_et = 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #2;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_init_done"}, 32'(init_done), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_draw_enable"}, 32'(draw_enable), 0);
      check({tag, "_acks"}, {30'd0, ackA, ackB}, 0);
      check({tag, "_errs"}, {30'd0, err_range, err_timeout}, 0);
      check({tag, "_X"}, 32'(X), 214);
      check({tag, "_Y"}, 32'(Y), 32);
      check({tag, "_OLD_X"}, 32'(OLD_X), 214);
      check({tag, "_OLD_Y"}, 32'(OLD_Y), 32);
      check({tag, "_state"}, 32'(state), 0);
   endtask

   // Plays vga_display: two drawing-high phases separated by one low cycle.
   task automatic serve(input int hi_len);
      int n = 0;
      while (!draw_enable && n < 20) begin tick(1); n++; end
      check("draw_enable_seen", 32'(draw_enable), 1);
      tick(1);
      drawing = 1; tick(hi_len);
      drawing = 0; tick(1);
      drawing = 1; tick(hi_len);
      drawing = 0;
      check("busy_before_last_fall", 32'(busy), 1);
      tick(1);
      check("busy_after_last_fall", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      nReset = 0; drawing = 0; reqB = 0; stateB = 0;
      newB_col = 0; newB_row = 0; oldB_col = 0; oldB_row = 0;
      // Cursor move request held from power-up; must wait for init to finish.
      reqA = 1; stateA = 1;
      newA_col = 2; newA_row = 3; oldA_col = 1; oldA_row = 3;
      push(0, K_DRAW, 280, 131, 247, 131, 1);
      tick(3);
      check_reset_vals("reset");
      nReset = 1;
      tick(3);
      check("init_pending", 32'(init_done), 0);
      drawing = 1; tick(100);
      drawing = 0;
      check("init_not_done_while_high", 32'(init_done), 0);
      tick(1);
      check("init_done_after_fall", 32'(init_done), 1);
      tick(1);
      reqA = 0;
      serve(4);

      // Out-of-range request from B: acked, err_range, no draw.
      newB_col = 12;
      push(1, K_RANGE, 0, 0, 0, 0, 0);
      reqB = 1;
      tick(1);
      reqB = 0;
      check("range_no_draw_enable", 32'(draw_enable), 0);
      check("range_busy_in_err", 32'(busy), 1);
      tick(1);
      check("range_back_idle", 32'(busy), 0);

      // Both requesting and held: A, B, A, B.
      newA_col = 0;  newA_row = 0;  oldA_col = 11; oldA_row = 11; stateA = 0;
      newB_col = 11; newB_row = 11; oldB_col = 5;  oldB_row = 6;  stateB = 1;
      push(0, K_DRAW, 214, 32, 577, 395, 0);
      push(1, K_DRAW, 577, 395, 379, 230, 1);
      push(0, K_DRAW, 214, 32, 577, 395, 0);
      push(1, K_DRAW, 577, 395, 379, 230, 1);
      reqA = 1; reqB = 1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin tick(1); reqA = 0; reqB = 0; end
         serve(2);
      end

      // drawing never rises after launch.
      newA_col = 4; newA_row = 5; oldA_col = 4; oldA_row = 4; stateA = 0;
      push(0, K_TIMEOUT, 346, 197, 346, 164, 0);
      reqA = 1;
      tick(1);
      reqA = 0;
      check("timeout_launch", 32'(draw_enable), 1);
      n = 0;
      do begin tick(1); n++; end while (!err_timeout && n < 40);
      check("timeout_cycles", 32'(n), 16);
      tick(1);
      check("timeout_back_idle", 32'(busy), 0);

      // Next request after a timeout is served normally.
      newB_col = 7; newB_row = 0; oldB_col = 0; oldB_row = 7; stateB = 1;
      push(1, K_DRAW, 445, 32, 214, 263, 1);
      reqB = 1;
      tick(1);
      reqB = 0;
      serve(3);

      // Reset while waiting in WAIT_LO1.
      newA_col = 1; newA_row = 1; oldA_col = 2; oldA_row = 2; stateA = 1;
      push(0, K_DRAW, 247, 65, 280, 98, 1);
      reqA = 1;
      tick(1);
      reqA = 0;
      tick(1);
      drawing = 1;
      tick(1);
      check("abort_busy_before", 32'(busy), 1);
      newB_col = 3; newB_row = 3; oldB_col = 3; oldB_row = 2; stateB = 0;
      reqB = 1;
      nReset = 0;
      #1;
      check_reset_vals("abort");
      tick(2);
      nReset = 1; drawing = 0;
      tick(3);
      check("reinit_busy", 32'(busy), 0);
      check("reinit_init_done", 32'(init_done), 0);
      push(1, K_DRAW, 313, 131, 313, 98, 0);
      drawing = 1; tick(5);
      drawing = 0; tick(1);
      check("reinit_done", 32'(init_done), 1);
      tick(1);
      reqB = 0;
      serve(2);

      tick(3);
      close_cur();
      check("scoreboard_drained", 32'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
